// File: rtl/axil_arbiter_rr_rd.sv
// Round-robin arbiter for the AXI-Lite read path.
// Grants one of NUMBER_MASTER masters and holds the grant for one whole read
// transaction: the AR handshake, then the R handshake. The one-hot grant and
// its encoded index are both registered, and they steer the AR/R muxes.
// After each win the search start rotates past the winner. Because of that,
// every master that keeps requesting is served within NUMBER_MASTER tenures.
module axil_arbiter_rr_rd #(
    parameter int NUMBER_MASTER = 2
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic [NUMBER_MASTER-1:0]         request_rd,
    output logic [NUMBER_MASTER-1:0]         grant_rd,
    output logic [$clog2(NUMBER_MASTER)-1:0] grant_rd_cdr,
    input  logic [NUMBER_MASTER-1:0]         m_axil_arvalid,
    input  logic                             s_axil_arready,
    input  logic                             s_axil_rvalid,
    input  logic [NUMBER_MASTER-1:0]         m_axil_rready
);

    localparam int                IDX_W    = $clog2(NUMBER_MASTER);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUMBER_MASTER - 1);

    typedef enum logic [1:0] {
        ST_IDLE,   // no tenure; waiting for any request
        ST_ARB,    // request_rd sampled, winner registered on this edge
        ST_ADDR,   // grant held, waiting for the AR handshake of the winner
        ST_DATA    // grant held, waiting for the R handshake of the winner
    } state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Rotating search: start one past the last winner, wrap at the top
    // index, and take the first requester found.
    function automatic pick_t rr_pick(input logic [NUMBER_MASTER-1:0] req,
                                      input logic [IDX_W-1:0]         last);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p    = '0;
        cand = last;
        for (int i = 0; i < NUMBER_MASTER; i++) begin
            cand = (cand == LAST_IDX) ? '0 : cand + 1'b1;
            if (!p.found && req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUMBER_MASTER-1:0] r_grant;
    logic [NUMBER_MASTER-1:0] w_grant_nxt;
    logic [IDX_W-1:0]         r_grant_cdr;
    logic [IDX_W-1:0]         w_grant_cdr_nxt;
    logic [IDX_W-1:0]         r_last_grant;
    logic [IDX_W-1:0]         w_last_grant_nxt;
    pick_t                    w_pick;
    logic                     w_ar_hs;
    logic                     w_r_hs;

    assign grant_rd     = r_grant;
    assign grant_rd_cdr = r_grant_cdr;

    // Only the granted master's valid/ready qualify a handshake.
    assign w_pick  = rr_pick(request_rd, r_last_grant);
    assign w_ar_hs = m_axil_arvalid[r_grant_cdr] && s_axil_arready;
    assign w_r_hs  = s_axil_rvalid && m_axil_rready[r_grant_cdr];

    // Next-state and next-grant decode for the tenure FSM.
    always_comb begin
        // NOTE: every variable gets a default before the case. If any path
        // left one of them unassigned, synthesis would infer a latch.
        w_state_nxt      = r_state;
        w_grant_nxt      = r_grant;
        w_grant_cdr_nxt  = r_grant_cdr;
        w_last_grant_nxt = r_last_grant;
        unique case (r_state)
            ST_IDLE: begin
                if (|request_rd) begin
                    w_state_nxt = ST_ARB;
                end
            end
            ST_ARB: begin
                if (w_pick.found) begin
                    w_grant_nxt              = '0;
                    w_grant_nxt[w_pick.idx]  = 1'b1;
                    w_grant_cdr_nxt          = w_pick.idx;
                    w_last_grant_nxt         = w_pick.idx;
                    w_state_nxt              = ST_ADDR;
                end else begin
                    // The request was withdrawn. No grant is made and the
                    // pointer keeps its value.
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ADDR: begin
                if (w_ar_hs) begin
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_r_hs) begin
                    w_grant_nxt     = '0;
                    w_grant_cdr_nxt = '0;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge aclk) begin
        // NOTE: sequential state uses non-blocking assignments only. All
        // registers then update together from their pre-edge values.
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant, encoded index and round-robin pointer registers. On reset the
    // pointer goes to the top index, so master 0 wins the first search.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_grant      <= '0;
            r_grant_cdr  <= '0;
            r_last_grant <= LAST_IDX;
        end else begin
            r_grant      <= w_grant_nxt;
            r_grant_cdr  <= w_grant_cdr_nxt;
            r_last_grant <= w_last_grant_nxt;
        end
    end

endmodule

// File: tb/tb_axil_arbiter_rr_rd.sv
// Testbench for axil_arbiter_rr_rd (NUMBER_MASTER = 4).
// A transaction-level reference tracks who owns the slave port. It is
// compared against the DUT on every falling edge. Directed scenarios with
// literal expectations pin down that reference. A randomized phase follows
// them.
module tb_axil_arbiter_rr_rd;

    localparam int N = 4;

    logic         aclk;
    logic         aresetn;
    logic [N-1:0] request_rd;
    logic [N-1:0] grant_rd;
    logic [1:0]   grant_rd_cdr;
    logic [N-1:0] m_axil_arvalid;
    logic         s_axil_arready;
    logic         s_axil_rvalid;
    logic [N-1:0] m_axil_rready;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 0;

    axil_arbiter_rr_rd #(.NUMBER_MASTER(N)) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .request_rd     (request_rd),
        .grant_rd       (grant_rd),
        .grant_rd_cdr   (grant_rd_cdr),
        .m_axil_arvalid (m_axil_arvalid),
        .s_axil_arready (s_axil_arready),
        .s_axil_rvalid  (s_axil_rvalid),
        .m_axil_rready  (m_axil_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model. It records which master owns the port, whether that
    // master's address phase is done, and whether a request was seen in idle.
    // It does this instead of modelling FSM states.
    int m_owner;
    int m_last;
    int m_k;
    bit m_armed;
    bit m_addr_done;

    always @(posedge aclk) begin
        if (!aresetn) begin
            m_owner     = -1;
            m_last      = N - 1;
            m_armed     = 0;
            m_addr_done = 0;
        end else if (m_owner < 0) begin
            if (m_armed) begin
                m_armed = 0;
                for (int d = 1; d <= N; d++) begin
                    m_k = (m_last + d) % N;
                    if (m_owner < 0 && request_rd[m_k]) begin
                        m_owner = m_k;
                        m_last  = m_k;
                    end
                end
            end else if (request_rd != 0) begin
                m_armed = 1;
            end
        end else if (!m_addr_done) begin
            if (m_axil_arvalid[m_owner] && s_axil_arready) m_addr_done = 1;
        end else if (s_axil_rvalid && m_axil_rready[m_owner]) begin
            m_owner     = -1;
            m_addr_done = 0;
        end
    end

    // Compare the DUT against the model every cycle, on the falling edge.
    always @(negedge aclk) begin
        if (cmp_en) begin
            check("model_grant", {28'd0, grant_rd}, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
            check("model_cdr", {30'd0, grant_rd_cdr}, (m_owner < 0) ? 32'd0 : 32'(m_owner));
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_bus();
        m_axil_arvalid = '0;
        s_axil_arready = 1'b0;
        s_axil_rvalid  = 1'b0;
        m_axil_rready  = '0;
    endtask

    task automatic reset_dut();
        request_rd = '0;
        clear_bus();
        aresetn = 1'b0;
        tick(); tick(); tick();
        aresetn = 1'b1;
    endtask

    // Starts when the grant to master k is visible (address phase). Returns
    // in the idle cycle that follows the release.
    task automatic do_txn(input int k);
        m_axil_arvalid[k] = 1'b1;
        s_axil_arready    = 1'b1;
        tick();
        clear_bus();
        s_axil_rvalid    = 1'b1;
        m_axil_rready[k] = 1'b1;
        tick();
        clear_bus();
        check("released", {28'd0, grant_rd}, 32'd0);
    endtask

    int exp_order [5] = '{0, 1, 2, 3, 0};

    initial begin
        aresetn    = 1'b0;
        request_rd = '0;
        clear_bus();
        tick();
        cmp_en = 1;

        // Reset check: requests are active but must be ignored.
        request_rd = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            check("rst_grant", {28'd0, grant_rd}, 32'd0);
            check("rst_cdr", {30'd0, grant_rd_cdr}, 32'd0);
            tick();
        end
        aresetn = 1'b1;
        tick(); tick();
        check("first_grant", {28'd0, grant_rd}, 32'b0001);

        // Single read, counted from cycle 0.
        reset_dut();
        request_rd = 4'b0100;                                              // cycle 0
        tick(); check("sr_c1", {28'd0, grant_rd}, 32'd0);                  // cycle 1
        tick(); check("sr_c2", {28'd0, grant_rd}, 32'b0100);               // cycle 2
        check("sr_c2_cdr", {30'd0, grant_rd_cdr}, 32'd2);
        request_rd = '0;
        tick(); check("sr_c3", {28'd0, grant_rd}, 32'b0100);               // cycle 3
        tick();                                                            // cycle 4
        m_axil_arvalid = 4'b0100; s_axil_arready = 1'b1;
        tick(); clear_bus(); check("sr_c5", {28'd0, grant_rd}, 32'b0100);  // cycle 5
        tick();                                                            // cycle 6
        check("sr_c6", {28'd0, grant_rd}, 32'b0100);
        s_axil_rvalid = 1'b1; m_axil_rready = 4'b0100;
        tick(); clear_bus();                                               // cycle 7
        check("sr_c7", {28'd0, grant_rd}, 32'd0);

        // Fairness: all four request continuously.
        reset_dut();
        request_rd = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("fair_gap", {28'd0, grant_rd}, 32'd0);
            tick();
            check("fair_grant", {28'd0, grant_rd}, 32'd1 << exp_order[i]);
            check("fair_cdr", {30'd0, grant_rd_cdr}, 32'(exp_order[i]));
            do_txn(exp_order[i]);
        end

        // Wrap search: after master 1, a search over 1001 must wrap to 3, then 0.
        reset_dut();
        request_rd = 4'b0010;
        tick(); tick();
        check("wrap_m1", {28'd0, grant_rd}, 32'b0010);
        do_txn(1);
        request_rd = 4'b1001;
        tick(); tick();
        check("wrap_m3", {28'd0, grant_rd}, 32'b1000);
        check("wrap_m3_cdr", {30'd0, grant_rd_cdr}, 32'd3);
        do_txn(3);
        tick(); tick();
        check("wrap_m0", {28'd0, grant_rd}, 32'b0001);
        do_txn(0);
        request_rd = '0;

        // Qualification: signals from non-granted masters must be ignored.
        reset_dut();
        request_rd = 4'b0010;
        tick(); tick();
        request_rd = '0;
        m_axil_arvalid = 4'b0001; s_axil_arready = 1'b1;
        tick(); tick();
        clear_bus();
        s_axil_rvalid = 1'b1; m_axil_rready = 4'b0010;   // would release if in DATA
        tick();
        clear_bus();
        check("qual_addr_hold", {28'd0, grant_rd}, 32'b0010);
        m_axil_arvalid = 4'b0010; s_axil_arready = 1'b1;
        tick();
        clear_bus();
        s_axil_rvalid = 1'b1; m_axil_rready = 4'b0001;
        tick();
        check("qual_data_hold", {28'd0, grant_rd}, 32'b0010);
        m_axil_rready = 4'b0011;
        tick();
        clear_bus();
        check("qual_release", {28'd0, grant_rd}, 32'd0);

        // Withdrawn request: a one-cycle pulse must not produce a grant.
        reset_dut();
        tick();
        request_rd = 4'b0100;
        tick();
        request_rd = '0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("withdraw_nogrant", {28'd0, grant_rd}, 32'd0);
        end
        request_rd = 4'b1111;
        tick(); tick();
        check("withdraw_ptr", {28'd0, grant_rd}, 32'b0001);
        request_rd = '0;
        do_txn(0);

        // Reset during the data phase.
        request_rd = 4'b0100;
        tick(); tick();
        request_rd = '0;
        m_axil_arvalid = 4'b0100; s_axil_arready = 1'b1;
        tick();
        clear_bus();
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        check("midrst_grant", {28'd0, grant_rd}, 32'd0);
        request_rd = 4'b1111;
        tick(); tick();
        check("midrst_m0", {28'd0, grant_rd}, 32'b0001);

        // Randomized phase; the model compare runs on every cycle.
        for (int i = 0; i < 3000; i++) begin
            tick();
            aresetn        = ($urandom_range(0, 299) != 0);
            request_rd     = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            m_axil_arvalid = 4'($urandom_range(0, 15));
            s_axil_arready = 1'($urandom_range(0, 1));
            s_axil_rvalid  = 1'($urandom_range(0, 1));
            m_axil_rready  = 4'($urandom_range(0, 15));
        end
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
